mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data and byte-address width.
REQ-002 Parameter ADDR_W, default 9: word-address width of the shared RAM.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flash_en  in  1  one-cycle flash write strobe.
REQ-006 flash_addr  in  WIDTH  flash byte address.
REQ-007 flash_data  in  WIDTH  flash write data.
REQ-008 if_req  in  1  instruction-fetch read request, held until if_valid.
REQ-009 if_addr  in  WIDTH  fetch byte address.
REQ-010 if_valid  out  1  fetch data valid, one-cycle pulse.
REQ-011 if_rdata  out  WIDTH  fetch data.
REQ-012 dm_req  in  1  data-port request, held until dm_valid.
REQ-013 dm_we  in  1  data-port write (1) / read (0).
REQ-014 dm_addr  in  WIDTH  data byte address.
REQ-015 dm_wdata  in  WIDTH  data write value.
REQ-016 dm_valid  out  1  data read-data valid or write-ack, one-cycle pulse.
REQ-017 dm_rdata  out  WIDTH  data read value.
REQ-018 mem_en  out  1  RAM access enable.
REQ-019 mem_we  out  1  RAM write enable.
REQ-020 mem_addr  out  ADDR_W  RAM word address.
REQ-021 mem_wdata  out  WIDTH  RAM write data.
REQ-022 mem_rdata  in  WIDTH  RAM read data, valid the cycle after a read issue.

Function
REQ-023 Requesters: FLASH, DATA, FETCH; at most one granted per cycle.
REQ-024 FLASH has absolute priority; flash_en always granted in its own cycle, never dropped or delayed.
REQ-025 Without flash_en, DATA vs FETCH resolved round-robin: last_grant register (DATA/FETCH); when both request, grant the one not granted last; single requester granted directly.
REQ-026 last_grant updates only on a DATA or FETCH grant; FLASH grants leave it unchanged.
REQ-027 Grant outputs are combinational in the grant cycle: mem_en=1, mem_we=1 for FLASH or DATA write, mem_addr=granted_addr[ADDR_W+1:2], mem_wdata=granted data; no grant -> mem_en=0, mem_we=0.
REQ-028 Address bits [1:0] and bits above ADDR_W+1 ignored; no alignment fault.
REQ-029 Latency: grant in cycle N -> requester's valid pulse in cycle N+1, rdata = mem_rdata (read) or don't-care (DATA write ack).
REQ-030 Registered pending-tag (NONE/DATA/FETCH) records the cycle-N grant; drives valid in N+1; FLASH grants produce no valid.
REQ-031 Back-to-back issue: a new grant may be made in cycle N+1 while cycle-N's response returns; throughput one access per cycle.
REQ-032 A requester granted in cycle N is not re-granted in N+1 even if req still high (req is dropped on valid); the other requester, if pending, wins N+1.
REQ-033 Simultaneous flash_en with pending DATA/FETCH: FLASH wins; losers keep waiting, no valid generated for them that cycle.
REQ-034 if_rdata/dm_rdata hold their last value when valid is low.
REQ-035 Starvation bound: a held DATA or FETCH request is granted within 2 cycles absent flash_en.

Reset
REQ-036 While rst=1: mem_en=0, mem_we=0, if_valid=0, dm_valid=0, pending-tag=NONE, last_grant=FETCH (DATA wins first tie), rdata registers=0.
REQ-037 flash_en during rst=1 is still granted and written (program load under reset); no other grants during rst.
REQ-038 rst asserted mid-access: in-flight response discarded, no valid pulse the following cycle.

Verification
REQ-039 rst=1, flash_en with addr 36 data 0x1, then addr 0 data 0x02402783 -> mem_we=1 mem_addr=9 then 0; no valid pulses.
REQ-040 rst=0, if_req addr 0 alone -> mem_en=1 mem_we=0 mem_addr=0 same cycle; next cycle if_valid=1, if_rdata=0x02402783.
REQ-041 if_req and dm_req (read addr 36) held from same cycle after reset -> DATA granted first (dm_valid next cycle, dm_rdata=0x1), FETCH granted following cycle.
REQ-042 dm_req write addr 40 data 0x7B coincident with flash_en addr 44 -> flash written cycle N, data write cycle N+1, dm_valid cycle N+2; read of 40 returns 0x7B.
REQ-043 Both requesters held continuously 8 cycles -> grants alternate strictly, 4 each, one valid per cycle after first.
REQ-044 rst asserted the cycle after a fetch grant -> if_valid stays 0; post-reset outputs match REQ-036.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared-RAM port bundle: flash loader, data port, fetch port and the RAM side.
// slave = arbiter view, master = requesters + RAM model view.
interface mem_port_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
);
  logic              flash_en;
  logic [WIDTH-1:0]  flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              if_req;
  logic [WIDTH-1:0]  if_addr;
  logic              if_valid;
  logic [WIDTH-1:0]  if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [WIDTH-1:0]  dm_addr;
  logic [WIDTH-1:0]  dm_wdata;
  logic              dm_valid;
  logic [WIDTH-1:0]  dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  flash_en, flash_addr, flash_data,
    input  if_req, if_addr,
    output if_valid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output flash_en, flash_addr, flash_data,
    output if_req, if_addr,
    input  if_valid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: flash has absolute priority, data/fetch alternate
// round-robin; one access per cycle, response returned the following cycle.
module mem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_if.slave  bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_DATA, TAG_FETCH} tag_e;
  typedef enum logic {LG_DATA, LG_FETCH} lg_e;

  tag_e             pend_q, pend_d;
  lg_e              last_q, last_d;
  logic [WIDTH-1:0] if_rdata_q, dm_rdata_q;

  logic             dm_ok, if_ok, gnt_dm, gnt_if;
  logic [WIDTH-1:0] sel_addr;
  logic             unused_addr_bits;

  // A requester whose response is returning this cycle is still holding req;
  // excluding it here keeps it from being granted twice.
  assign dm_ok = bus.dm_req && !rst && (pend_q != TAG_DATA);
  assign if_ok = bus.if_req && !rst && (pend_q != TAG_FETCH);

  always_comb begin
    gnt_dm = 1'b0;
    gnt_if = 1'b0;
    last_d = last_q;
    pend_d = TAG_NONE;
    if (!bus.flash_en) begin
      if (dm_ok && if_ok) begin
        gnt_dm = (last_q == LG_FETCH);
        gnt_if = (last_q == LG_DATA);
      end else begin
        gnt_dm = dm_ok;
        gnt_if = if_ok;
      end
    end
    if (gnt_dm) begin
      pend_d = TAG_DATA;
      last_d = LG_DATA;
    end else if (gnt_if) begin
      pend_d = TAG_FETCH;
      last_d = LG_FETCH;
    end
  end

  always_comb begin
    sel_addr = bus.if_addr;
    if (bus.flash_en)  sel_addr = bus.flash_addr;
    else if (gnt_dm)   sel_addr = bus.dm_addr;
  end

  assign bus.mem_en    = bus.flash_en | gnt_dm | gnt_if;
  assign bus.mem_we    = bus.flash_en | (gnt_dm & bus.dm_we);
  assign bus.mem_addr  = sel_addr[ADDR_W+1:2];
  assign bus.mem_wdata = bus.flash_en ? bus.flash_data : bus.dm_wdata;
  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[WIDTH-1:ADDR_W+2]};

  // Valid is gated by rst so a response in flight when reset hits is dropped.
  assign bus.if_valid = !rst && (pend_q == TAG_FETCH);
  assign bus.dm_valid = !rst && (pend_q == TAG_DATA);
  assign bus.if_rdata = bus.if_valid ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata = bus.dm_valid ? bus.mem_rdata : dm_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= TAG_NONE;
      last_q     <= LG_FETCH;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      if (bus.if_valid) if_rdata_q <= bus.mem_rdata;
      if (bus.dm_valid) dm_rdata_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural RAM, expected read data
// queued per requester when a request is raised, checked on the valid pulse.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_if #(.WIDTH(32), .ADDR_W(9)) bus ();

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] ram [512];
  logic [31:0] rdq;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            rdq <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdq;

  typedef struct {logic wr; logic [31:0] d;} exp_t;
  exp_t        dq[$];
  logic [31:0] iq[$];
  logic [31:0] rm [512];
  int nchk = 0, nerr = 0, vcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.flash_en = 1'b0;
  endtask

  // Called mid-cycle after inputs are set: scores any valid pulse this cycle.
  task automatic mon();
    exp_t e;
    #1;
    chk("if_spur", 32'(bus.if_valid && iq.size() == 0), 0);
    chk("dm_spur", 32'(bus.dm_valid && dq.size() == 0), 0);
    if (bus.if_valid && iq.size() != 0) begin
      vcnt++;
      chk("if_rdata", bus.if_rdata, iq.pop_front());
      bus.if_req = 1'b0;
    end
    if (bus.dm_valid && dq.size() != 0) begin
      vcnt++;
      e = dq.pop_front();
      if (!e.wr) chk("dm_rdata", bus.dm_rdata, e.d);
      bus.dm_req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 6 && (iq.size() != 0 || dq.size() != 0); n++) begin
      cyc();
      mon();
    end
    chk("drain", 32'(iq.size() + dq.size()), 0);
  endtask

  task automatic flash(input logic [31:0] a, input logic [31:0] d);
    bus.flash_en = 1'b1;
    bus.flash_addr = a;
    bus.flash_data = d;
    rm[a[10:2]] = d;
  endtask

  task automatic dm_read(input logic [31:0] a);
    cyc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = a;
    dq.push_back('{1'b0, rm[a[10:2]]});
    mon();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nd, nf, v0;
    logic g, prev;
    rst = 1'b1;
    bus.flash_en = 0; bus.flash_addr = 0; bus.flash_data = 0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    for (int i = 0; i < 512; i++) rm[i] = 'x;

    // reset state, and no data/fetch grant while in reset
    cyc(); mon(); cyc();
    bus.if_req = 1'b1;
    mon();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_if_valid", 32'(bus.if_valid), 0);
    chk("rst_dm_valid", 32'(bus.dm_valid), 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    bus.if_req = 1'b0;

    // program load under reset
    cyc(); flash(36, 32'h1); mon();
    chk("ld0_en", 32'(bus.mem_en), 1);
    chk("ld0_we", 32'(bus.mem_we), 1);
    chk("ld0_addr", 32'(bus.mem_addr), 9);
    chk("ld0_wdata", bus.mem_wdata, 32'h1);
    cyc(); flash(0, 32'h0240_2783); mon();
    chk("ld1_we", 32'(bus.mem_we), 1);
    chk("ld1_addr", 32'(bus.mem_addr), 0);
    cyc(); mon();
    chk("ld_no_ifv", 32'(bus.if_valid), 0);
    chk("ld_no_dmv", 32'(bus.dm_valid), 0);

    // single fetch
    cyc(); rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 0; iq.push_back(rm[0]);
    mon();
    chk("f_en", 32'(bus.mem_en), 1);
    chk("f_we", 32'(bus.mem_we), 0);
    chk("f_addr", 32'(bus.mem_addr), 0);
    cyc(); mon();
    chk("f_valid", 32'(bus.if_valid), 1);
    cyc(); mon();
    chk("f_vlow", 32'(bus.if_valid), 0);
    chk("f_hold", bus.if_rdata, 32'h0240_2783);

    // tie right after reset: DATA first, FETCH next
    cyc(); rst = 1'b1; mon();
    cyc(); rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 0; iq.push_back(rm[0]);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 36; dq.push_back('{1'b0, rm[9]});
    mon();
    chk("tie_addr_data", 32'(bus.mem_addr), 9);
    cyc(); mon();
    chk("tie_dm_valid", 32'(bus.dm_valid), 1);
    chk("tie_en2", 32'(bus.mem_en), 1);
    chk("tie_addr_fetch", 32'(bus.mem_addr), 0);
    cyc(); mon();
    chk("tie_if_valid", 32'(bus.if_valid), 1);

    // data write colliding with flash
    cyc(); mon();
    cyc(); flash(44, 32'h55);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 40; bus.dm_wdata = 32'h7B;
    rm[10] = 32'h7B; dq.push_back('{1'b1, 32'h0});
    mon();
    chk("col_flash_addr", 32'(bus.mem_addr), 11);
    chk("col_flash_wdata", bus.mem_wdata, 32'h55);
    cyc(); mon();
    chk("col_no_dmv", 32'(bus.dm_valid), 0);
    chk("col_dm_we", 32'(bus.mem_we), 1);
    chk("col_dm_addr", 32'(bus.mem_addr), 10);
    chk("col_dm_wdata", bus.mem_wdata, 32'h7B);
    cyc(); mon();
    chk("col_dm_ack", 32'(bus.dm_valid), 1);
    dm_read(40);
    dm_read(44);
    dm_read(32'hFFFF_F82B);  // upper and low bits ignored -> word 10

    // both requesters held continuously: strict alternation
    cyc(); mon();
    nd = 0; nf = 0; prev = 1'b0;
    bus.if_addr = 0; bus.dm_addr = 36; bus.dm_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (!bus.if_req) begin bus.if_req = 1'b1; iq.push_back(rm[0]); end
      if (!bus.dm_req) begin bus.dm_req = 1'b1; dq.push_back('{1'b0, rm[9]}); end
      v0 = vcnt;
      mon();
      chk("rr_en", 32'(bus.mem_en), 1);
      g = (bus.mem_addr == 9);
      if (g) nd++; else nf++;
      if (k > 0) begin
        chk("rr_alt", 32'(g), 32'(!prev));
        chk("rr_one_valid", 32'(vcnt - v0), 1);
      end
      prev = g;
    end
    chk("rr_cnt_data", 32'(nd), 4);
    chk("rr_cnt_fetch", 32'(nf), 4);
    drain();

    // reset the cycle after a fetch grant
    cyc(); mon();
    cyc(); bus.if_req = 1'b1; bus.if_addr = 0; mon();
    chk("rf_grant", 32'(bus.mem_en), 1);
    cyc(); rst = 1'b1; mon();
    chk("rf_no_valid", 32'(bus.if_valid), 0);
    chk("rf_no_en", 32'(bus.mem_en), 0);
    cyc(); bus.if_req = 1'b0; mon();
    chk("rf_no_valid2", 32'(bus.if_valid), 0);
    cyc(); rst = 1'b0; mon();
    chk("rf_mem_en", 32'(bus.mem_en), 0);
    chk("rf_dm_valid", 32'(bus.dm_valid), 0);
    chk("rf_if_rdata", bus.if_rdata, 0);
    chk("rf_dm_rdata", bus.dm_rdata, 0);
    cyc(); mon();
    chk("rf_if_valid", 32'(bus.if_valid), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
